// File: rtl/branch_resolve.sv
// Branch resolution stage: evaluates the condition code against the registered flags and
// issues a PC load plus a timed flush. Define BRANCH_STATS_EN to add taken/not-taken counters.
module branch_resolve #(
    parameter int ADDR_WIDTH   = 16,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  branchValid,
    input  logic [3:0]            branchCond,
    input  logic [ADDR_WIDTH-1:0] branchTarget,
    output logic                  branchReady,
    input  logic                  setsFlags,
    input  logic                  arithCarry,
    input  logic                  logicCarry,
    input  logic                  sign,
    input  logic                  overflow,
    input  logic                  zero,
    input  logic [1:0]            carrySelect,
    output logic                  pcLoad,
    output logic [ADDR_WIDTH-1:0] pcTarget,
    output logic                  flush,
    output logic                  stall
`ifdef BRANCH_STATS_EN
    ,
    output logic [15:0]           takenCount,
    output logic [15:0]           notTakenCount
`endif
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;

    localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    logic [1:0]            state_q, state_d;
    logic [3:0]            cond_q, cond_d;
    logic [ADDR_WIDTH-1:0] hold_q, hold_d;
    logic [ADDR_WIDTH-1:0] pct_q, pct_d;
    logic                  pcl_q, pcl_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  zero_q, zero_d;

    logic                  carry;
    logic [3:0]            eval_cond;
    logic                  taken_now;
    logic                  dep_accept;

    function automatic logic cond_eval(input logic [3:0] c, input logic cf, input logic zf,
                                       input logic sf, input logic vf);
        logic r;
        case (c)
            4'd0:    r = 1'b1;
            4'd1:    r = zf;
            4'd2:    r = !zf;
            4'd3:    r = cf;
            4'd4:    r = !cf;
            4'd5:    r = sf;
            4'd6:    r = !sf;
            4'd7:    r = vf;
            4'd8:    r = !vf;
            4'd9:    r = cf & !zf;
            4'd10:   r = !cf | zf;
            4'd11:   r = (sf == vf);
            4'd12:   r = (sf != vf);
            4'd13:   r = !zf & (sf == vf);
            4'd14:   r = zf | (sf != vf);
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    always_comb begin
        case (carrySelect)
            2'd0:    carry = arithCarry;
            2'd1:    carry = logicCarry;
            2'd2:    carry = 1'b0;
            default: carry = 1'b1;
        endcase
    end

    // WAIT re-evaluates the captured condition once the dependent flags have landed
    assign eval_cond  = (state_q == S_WAIT) ? cond_q : branchCond;
    assign taken_now  = cond_eval(eval_cond, carry, zero_q, sign, overflow);
    assign dep_accept = (state_q == S_IDLE) && branchValid && setsFlags;

    always_comb begin
        state_d = state_q;
        cond_d  = cond_q;
        hold_d  = hold_q;
        pct_d   = pct_q;
        pcl_d   = 1'b0;
        cnt_d   = cnt_q;
        zero_d  = setsFlags ? zero : zero_q;
        case (state_q)
            S_IDLE: begin
                if (branchValid) begin
                    if (setsFlags) begin
                        cond_d  = branchCond;
                        hold_d  = branchTarget;
                        state_d = S_WAIT;
                    end else if (taken_now) begin
                        pct_d   = branchTarget;
                        pcl_d   = 1'b1;
                        cnt_d   = CW'(FLUSH_CYCLES - 1);
                        state_d = S_FLUSH;
                    end
                end
            end
            S_WAIT: begin
                if (taken_now) begin
                    pct_d   = hold_q;
                    pcl_d   = 1'b1;
                    cnt_d   = CW'(FLUSH_CYCLES - 1);
                    state_d = S_FLUSH;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FLUSH: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cond_q  <= '0;
            hold_q  <= '0;
            pct_q   <= '0;
            pcl_q   <= 1'b0;
            cnt_q   <= '0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cond_q  <= cond_d;
            hold_q  <= hold_d;
            pct_q   <= pct_d;
            pcl_q   <= pcl_d;
            cnt_q   <= cnt_d;
            zero_q  <= zero_d;
        end
    end

    assign branchReady = (state_q == S_IDLE) && !(branchValid && setsFlags);
    assign stall       = (state_q == S_WAIT) || dep_accept;
    assign flush       = (state_q == S_FLUSH);
    assign pcLoad      = pcl_q;
    assign pcTarget    = pct_q;

`ifdef BRANCH_STATS_EN
    logic        resolve;
    logic [15:0] taken_q, ntaken_q;

    assign resolve = ((state_q == S_IDLE) && branchValid && !setsFlags) || (state_q == S_WAIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            taken_q  <= '0;
            ntaken_q <= '0;
        end else if (resolve) begin
            if (taken_now && taken_q != '1) begin
                taken_q <= taken_q + 16'd1;
            end
            if (!taken_now && ntaken_q != '1) begin
                ntaken_q <= ntaken_q + 16'd1;
            end
        end
    end

    assign takenCount    = taken_q;
    assign notTakenCount = ntaken_q;
`endif

endmodule
